puf_sampler: RTL and testbench
==============================

PUF_SAMPLER -- requirements
Module: puf_sampler

Interface
REQ-001 SHALL have parameter N, 64, challenge width; equals arbiter stage count.
REQ-002 SHALL have parameter K, 7, races per challenge for majority vote; odd, 1..31.
REQ-003 SHALL have parameter SETTLE_CYC, 8, cycles launch is held high per race; at least 3.
REQ-004 SHALL have parameter RELAX_CYC, 4, cycles launch is held low after each race; at least 1.
REQ-005 SHALL have port clk, input, 1, sole clock.
REQ-006 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port chal_valid, input, 1, challenge offered.
REQ-008 SHALL have port chal_ready, output, 1, sampler accepts challenge.
REQ-009 SHALL have port chal_in, input, N, challenge vector.
REQ-010 SHALL have port launch, output, 1, race launch to arbiter.
REQ-011 SHALL have port challenge, output, N, registered challenge to arbiter.
REQ-012 SHALL have port response, input, 1, arbiter latch output; asynchronous.
REQ-013 SHALL have port resp_valid, output, 1, voted response available.
REQ-014 SHALL have port resp_ready, input, 1, consumer takes response.
REQ-015 SHALL have port resp_bit, output, 1, majority-voted response.

Function
REQ-016 SHALL implement FSM states IDLE, RACE, RELAX, DONE.
REQ-017 SHALL assert chal_ready only in IDLE; chal_valid outside IDLE is ignored.
REQ-018 SHALL, on chal_valid&chal_ready, register chal_in into challenge, clear counters, and enter RACE.
REQ-019 SHALL hold challenge stable from acceptance until the next acceptance.
REQ-020 SHALL drive launch=1 in RACE only, as a registered output, for exactly SETTLE_CYC cycles per race.
REQ-021 SHALL pass response through a 2-flop synchronizer and sample the synchronized value on the last RACE cycle.
REQ-022 SHALL increment ones_cnt when the sample is 1 and always increment race_cnt; both counters are $clog2(K+1) bits wide.
REQ-023 SHALL hold launch=0 in RELAX for exactly RELAX_CYC cycles, then go to RACE if race_cnt<K, else to DONE.
REQ-024 SHALL, in DONE, drive resp_bit = (ones_cnt > K/2) and resp_valid=1, both stable until resp_ready.
REQ-025 SHALL leave DONE for IDLE on resp_valid&resp_ready; chal_ready rises the following cycle, with no same-cycle bypass.
REQ-026 SHALL assert resp_valid exactly K*(SETTLE_CYC+RELAX_CYC) cycles after the acceptance edge.
REQ-027 SHALL ignore resp_ready while resp_valid=0.

Reset
REQ-028 SHALL, on rst, set state IDLE, launch=0, challenge=0, resp_valid=0, resp_bit=0, counters=0, synchronizer=0.
REQ-029 SHALL abort any transaction in progress on rst, without producing a response; launch falls on the reset edge.

Configuration
REQ-030 SHALL, with PUF_RAW_COUNT_EN defined, add output ones_count [$clog2(K+1)-1:0], valid with resp_valid and equal to ones_cnt.
REQ-031 SHALL, without PUF_RAW_COUNT_EN, omit the ones_count port; all other behaviour is identical.

Structure
REQ-032 SHALL take the state enum, SYNC_STAGES=2, and the parameter default constants from shared package puf_pkg.
REQ-033 SHALL instantiate sub-module puf_sync2 (2-flop synchronizer, synchronous reset) for response.
REQ-034 SHALL not instantiate the arbiter; the top level connects launch, challenge and response.
REQ-035 SHALL fail elaboration on even K, K>31, SETTLE_CYC<3 or RELAX_CYC<1.

Verification
REQ-036 SHALL cover: model response=1 always, K=7, chal_in=64'hDEAD_BEEF_0123_4567 -> resp_bit=1, ones_count=7, resp_valid 84 cycles after accept.
REQ-037 SHALL cover: model gives 1,0,1,0,1,0,0 per race -> resp_bit=0, ones_count=3.
REQ-038 SHALL cover: exactly 4 of 7 races return 1 -> resp_bit=1; the launch pulse count equals 7, each 8 cycles high and 4 low.
REQ-039 SHALL cover: resp_ready low for 20 cycles after resp_valid -> resp_bit held stable, chal_ready=0 throughout, and chal_valid pulses are ignored.
REQ-040 SHALL cover: rst asserted in the 3rd race -> launch=0, chal_ready=1 the next cycle, no resp_valid; a new challenge then completes normally.
REQ-041 SHALL cover: back-to-back challenges with resp_ready tied high -> one idle cycle between resp_valid and the next chal_ready, and challenge changes only at acceptance.

Source files
------------

// File: rtl/puf_pkg.sv
// puf_pkg -- shared definitions for the arbiter-PUF sampler.
//   puf_state_t   : sampler FSM states (IDLE, RACE, RELAX, DONE)
//   SYNC_STAGES   : depth of the response synchronizer
//   DEF_*         : default values for the puf_sampler parameters
//   max2()        : helper used to size the shared phase counter
package puf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RACE  = 2'd1,
    RELAX = 2'd2,
    DONE  = 2'd3
  } puf_state_t;

  localparam int SYNC_STAGES    = 2;

  localparam int DEF_N          = 64;
  localparam int DEF_K          = 7;
  localparam int DEF_SETTLE_CYC = 8;
  localparam int DEF_RELAX_CYC  = 4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/puf_sync2.sv
// puf_sync2 -- 2-flop synchronizer for the asynchronous arbiter latch output.
// Ports:
//   clk   : sampling clock
//   rst   : synchronous active-high reset, clears every stage
//   d     : asynchronous input
//   q     : synchronized output (SYNC_STAGES cycles of latency)
module puf_sync2
  import puf_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clk) begin
    if (rst) begin
      stages <= '0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/puf_sampler.sv
// puf_sampler -- drives an external arbiter PUF: accepts a challenge, fires K
// races (launch high SETTLE_CYC cycles, low RELAX_CYC cycles), samples the
// synchronized arbiter output at the end of each race and reports the
// majority vote.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   chal_valid/chal_ready  : challenge handshake, chal_in is the challenge
//   launch, challenge      : race launch and registered challenge to arbiter
//   response               : asynchronous arbiter latch output
//   resp_valid/resp_ready  : response handshake, resp_bit is the voted bit
//   ones_count             : number of races that returned 1
//                            (only present when PUF_RAW_COUNT_EN is defined)
module puf_sampler
  import puf_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int K          = DEF_K,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int RELAX_CYC  = DEF_RELAX_CYC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   chal_valid,
  output logic                   chal_ready,
  input  logic [N-1:0]           chal_in,
  output logic                   launch,
  output logic [N-1:0]           challenge,
  input  logic                   response,
  output logic                   resp_valid,
  input  logic                   resp_ready,
`ifdef PUF_RAW_COUNT_EN
  output logic [$clog2(K+1)-1:0] ones_count,
`endif
  output logic                   resp_bit
);

  localparam int CW = $clog2(K+1);
  // One counter times both the RACE and RELAX phases, so size it for the longer.
  localparam int PW = $clog2(max2(SETTLE_CYC, RELAX_CYC));

  if ((K % 2) == 0 || K < 1 || K > 31 || SETTLE_CYC < 3 || RELAX_CYC < 1) begin : g_param_check
    $error("puf_sampler: K must be odd in 1..31, SETTLE_CYC >= 3, RELAX_CYC >= 1");
  end

  puf_state_t     state;
  logic [PW-1:0]  phase;
  logic [CW-1:0]  race_cnt;
  logic [CW-1:0]  ones_cnt;
  logic           resp_sync;

  puf_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (response),
    .q   (resp_sync)
  );

  // No bypass: after the response handshake the FSM must first land in IDLE.
  assign chal_ready = (state == IDLE);

`ifdef PUF_RAW_COUNT_EN
  assign ones_count = ones_cnt;
`endif

  // launch is registered and changes together with the state, so it is high
  // exactly in the RACE cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= '0;
      race_cnt   <= '0;
      ones_cnt   <= '0;
      launch     <= 1'b0;
      challenge  <= '0;
      resp_valid <= 1'b0;
      resp_bit   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (chal_valid) begin
            challenge <= chal_in;
            race_cnt  <= '0;
            ones_cnt  <= '0;
            phase     <= '0;
            launch    <= 1'b1;
            state     <= RACE;
          end
        end
        RACE: begin
          if (phase == PW'(SETTLE_CYC - 1)) begin
            // Last settle cycle: the synchronized arbiter decision is final.
            phase    <= '0;
            launch   <= 1'b0;
            race_cnt <= race_cnt + CW'(1);
            ones_cnt <= ones_cnt + CW'(resp_sync);
            state    <= RELAX;
          end else begin
            phase <= phase + PW'(1);
          end
        end
        RELAX: begin
          if (phase == PW'(RELAX_CYC - 1)) begin
            phase <= '0;
            if (race_cnt < CW'(K)) begin
              launch <= 1'b1;
              state  <= RACE;
            end else begin
              resp_valid <= 1'b1;
              resp_bit   <= (ones_cnt > CW'(K / 2));
              state      <= DONE;
            end
          end else begin
            phase <= phase + PW'(1);
          end
        end
        DONE: begin
          if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_sampler.sv
// tb_puf_sampler -- self-checking bench for puf_sampler (default parameters).
// Plays the arbiter: each race returns a planned bit while launch is high and
// noise while it is low. Launch shape, response latency, vote result and the
// handshakes are predicted from cycle arithmetic relative to acceptance.
module tb_puf_sampler;

  localparam int N   = 64;
  localparam int K   = 7;
  localparam int S   = 8;
  localparam int R   = 4;
  localparam int P   = S + R;
  localparam int LAT = K * P;

  logic           clk = 1'b0;
  logic           rst;
  logic           chal_valid;
  logic           chal_ready;
  logic [N-1:0]   chal_in;
  logic           launch;
  logic [N-1:0]   challenge;
  logic           response;
  logic           resp_valid;
  logic           resp_ready;
  logic           resp_bit;
`ifdef PUF_RAW_COUNT_EN
  logic [$clog2(K+1)-1:0] ones_count;
`endif

  int           vectors = 0;
  int           errors  = 0;
  logic [N-1:0] model_chal;

  always #5 clk = ~clk;

  puf_sampler dut (
    .clk        (clk),
    .rst        (rst),
    .chal_valid (chal_valid),
    .chal_ready (chal_ready),
    .chal_in    (chal_in),
    .launch     (launch),
    .challenge  (challenge),
    .response   (response),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
`ifdef PUF_RAW_COUNT_EN
    .ones_count (ones_count),
`endif
    .resp_bit   (resp_bit)
  );

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One challenge transaction. bits[r] is what the arbiter returns in race r.
  // hold: cycles resp_ready stays low once the response is up.
  // noisy_ready: toggle resp_ready randomly while no response is pending.
  // abort_race: race in which reset is pulsed (-1 = none).
  task automatic applyStimulus(input logic [N-1:0] chal, input logic [K-1:0] bits,
                               input int hold, input bit noisy_ready, input int abort_race);
    int  ones;
    bit  exp_bit;
    int  pulses;
    bit  prev_launch;
    int  t;
    int  n;
    ones = 0;
    for (int i = 0; i < K; i++) ones += bits[i];
    exp_bit = (ones > K / 2);

    t = 0;
    while (chal_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    checkOutput("chal_ready_before_accept", chal_ready, 1'b1);
    checkOutput("challenge_before_accept", challenge, model_chal);

    chal_in    = chal;
    chal_valid = 1'b1;
    @(negedge clk);
    chal_valid = 1'b0;
    chal_in    = {$urandom, $urandom};
    model_chal = chal;

    pulses      = 0;
    prev_launch = 1'b0;
    n           = 0;
    while (n <= LAT) begin
      checkOutput("launch_shape", launch, (n < LAT) && ((n % P) < S));
      checkOutput("resp_valid_timing", resp_valid, n == LAT);
      checkOutput("challenge_hold", challenge, model_chal);
      if (n < LAT) checkOutput("chal_ready_busy", chal_ready, 1'b0);
      if (launch === 1'b1 && !prev_launch) pulses++;
      prev_launch = (launch === 1'b1);
      if (n == LAT) break;
      if (abort_race >= 0 && n == abort_race * P + S / 2) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_chal = '0;
        checkOutput("abort_launch", launch, 1'b0);
        checkOutput("abort_chal_ready", chal_ready, 1'b1);
        checkOutput("abort_resp_valid", resp_valid, 1'b0);
        checkOutput("abort_challenge", challenge, '0);
        resp_ready = 1'b0;
        return;
      end
      response   = ((n % P) < S) ? bits[n / P] : 1'($urandom);
      resp_ready = noisy_ready ? 1'($urandom) : 1'b0;
      @(negedge clk);
      n++;
    end
    checkOutput("launch_pulse_count", pulses, K);

    resp_ready = 1'b0;
    for (int c = 0; c < hold; c++) begin
      checkOutput("hold_resp_valid", resp_valid, 1'b1);
      checkOutput("hold_resp_bit", resp_bit, exp_bit);
      checkOutput("hold_chal_ready", chal_ready, 1'b0);
      checkOutput("hold_challenge", challenge, model_chal);
      chal_valid = 1'($urandom);
      chal_in    = {$urandom, $urandom};
      @(negedge clk);
    end

    checkOutput("resp_valid", resp_valid, 1'b1);
    checkOutput("resp_bit", resp_bit, exp_bit);
`ifdef PUF_RAW_COUNT_EN
    checkOutput("ones_count", ones_count, ones);
`endif
    checkOutput("chal_ready_in_done", chal_ready, 1'b0);
    // A challenge offered in the handshake cycle itself must not be taken.
    resp_ready = 1'b1;
    chal_valid = 1'b1;
    chal_in    = {$urandom, $urandom};
    @(negedge clk);
    chal_valid = 1'b0;
    resp_ready = 1'b0;
    checkOutput("resp_valid_cleared", resp_valid, 1'b0);
    checkOutput("chal_ready_after_done", chal_ready, 1'b1);
    checkOutput("challenge_no_bypass", challenge, model_chal);
  endtask

  initial begin
    rst        = 1'b1;
    chal_valid = 1'b0;
    chal_in    = '0;
    response   = 1'b0;
    resp_ready = 1'b0;
    model_chal = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_launch", launch, 1'b0);
    checkOutput("reset_chal_ready", chal_ready, 1'b1);
    checkOutput("reset_resp_valid", resp_valid, 1'b0);
    checkOutput("reset_resp_bit", resp_bit, 1'b0);
    checkOutput("reset_challenge", challenge, '0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] all-ones arbiter, fixed challenge");
    applyStimulus(64'hDEAD_BEEF_0123_4567, 7'b1111111, 0, 1'b0, -1);

    $display("[TB] alternating 1,0,1,0,1,0,0");
    applyStimulus({$urandom, $urandom}, 7'b0010101, 0, 1'b1, -1);

    $display("[TB] exactly four ones");
    applyStimulus({$urandom, $urandom}, 7'b1010011, 0, 1'b1, -1);

    $display("[TB] consumer stalls 20 cycles");
    applyStimulus({$urandom, $urandom}, 7'($urandom), 20, 1'b1, -1);

    $display("[TB] reset during third race");
    applyStimulus({$urandom, $urandom}, 7'b1111111, 0, 1'b0, 2);
    for (int c = 0; c < 6; c++) begin
      checkOutput("post_abort_resp_valid", resp_valid, 1'b0);
      checkOutput("post_abort_launch", launch, 1'b0);
      @(negedge clk);
    end
    applyStimulus({$urandom, $urandom}, 7'($urandom), 0, 1'b0, -1);

    $display("[TB] back-to-back random challenges");
    for (int i = 0; i < 6; i++) begin
      applyStimulus({$urandom, $urandom}, 7'($urandom), 0, 1'b1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
